univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal register, successor to the single-bit D flip-flop.
//  Supports hold, parallel load, shift, rotate, arithmetic shift and clear.
//  A multi-cycle burst-shift sequencer uses a start/busy/done handshake.
//  Used as a datapath shift/serialiser element.
// PARAMETERS
//  WIDTH     8   register width in bits (>=2)
//  AMT_W     4   width of burst shift-count input
//  RESET_VAL 0   value of q after reset and after CLR
// PORTS
//  clk     in   1        rising-edge clock
//  reset   in   1        asynchronous, active-high reset
//  en      in   1        op enable; during BURST, en=0 stalls the burst
//  mode    in   3        op select (codes below)
//  d       in   WIDTH    parallel load data
//  sin_l   in   1        serial in, enters MSB on SHR
//  sin_r   in   1        serial in, enters LSB on SHL
//  start   in   1        begin burst of `amount` repetitions of `mode`
//  amount  in   AMT_W    burst repeat count
//  q       out  WIDTH    register contents
//  sout_l  out  1        q[WIDTH-1], combinational
//  sout_r  out  1        q[0], combinational
//  busy    out  1        high while a burst is executing
//  done    out  1        one-cycle pulse when a burst completes
// BEHAVIOUR
//  Mode codes:
//   0 HOLD
//   1 LOAD q<=d
//   2 SHL {q[W-2:0],sin_r}
//   3 SHR {sin_l,q[W-1:1]}
//   4 ROL
//   5 ROR
//   6 ASR {q[W-1],q[W-1:1]}
//   7 CLR q<=RESET_VAL
//  Reset (async, any time, including mid-burst):
//   q=RESET_VAL, busy=0, done=0, cnt=0, state=IDLE.
//  FSM states: IDLE, BURST.
//  IDLE, start=0, en=1: one op per edge; q valid 1 cycle after the edge.
//  IDLE, start=1: start takes priority, en is ignored, q is unchanged that edge.
//   - Latch op=mode, cnt=amount.
//   - If amount!=0: busy<=1, go to BURST.
//   - If amount==0: done<=1 next cycle, no op, busy stays 0.
//  BURST, en=1: apply latched op once per edge, cnt--.
//   - On the edge where cnt==1: op applied, busy<=0, done<=1, go to IDLE.
//  BURST, en=0: stall; q and cnt hold, busy stays 1.
//  BURST: start, mode, amount and d are ignored; sin_l/sin_r are sampled live each shift.
//  Timing: N shifts -> busy high N cycles (no stalls); done high the cycle busy falls.
//  Non-shift latched op (HOLD/LOAD/CLR) repeats N times; LOAD uses d latched at start.
//  done is a registered pulse, exactly 1 cycle, cleared on the following edge.
//  amount = 2^AMT_W-1 is legal; cnt never wraps below 0.
// STRUCTURE
//  Package univ_shift_pkg holds:
//   - mode localparams MODE_HOLD..MODE_CLR
//   - state encodings S_IDLE/S_BURST
//  Sub-module univ_shift_next (combinational):
//   - inputs q, op, d, sin_l, sin_r
//   - output next-q
//   - instantiated once, muxed by FSM
//  Top holds q reg, cnt, latched op/d, FSM, done reg.
// TESTING
//  1 Reset mid-op: reset=1 while q=8'hA5 -> q=8'h00, busy=0, done=0 immediately (async).
//  2 Single ops, en=1:
//    LOAD d=8'h81, then SHL sin_r=1 -> 8'h03;
//    ROR -> 8'h81;
//    ASR -> 8'hC0;
//    CLR -> 8'h00.
//  3 Burst: q=8'h01, mode=ROL, amount=3, start 1 cycle
//    -> busy 3 cycles, q=8'h08, done 1 cycle.
//  4 Stall: as 3, but en=0 for 2 cycles mid-burst
//    -> busy 5 cycles, q holds during stall, final q=8'h08.
//  5 Edge cases:
//    amount=0 start -> done next cycle, busy never 1, q unchanged;
//    start+en both high in IDLE -> no en op.
//  6 Reset during BURST (cnt=2) -> IDLE, busy=0, no done pulse; new burst works afterwards.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// univ_shift_pkg
//   Shared definitions for the universal shift register slice.
//   - Mode (operation) codes used on the `mode` input and the latched op.
//   - FSM state type for the burst sequencer.
// ----------------------------------------------------------------------------
package univ_shift_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/univ_shift_next.sv
// ----------------------------------------------------------------------------
// univ_shift_next
//   Purely combinational next-value function of the universal register.
//   Ports:
//     q      in  WIDTH  current register contents
//     op     in  3      operation code (MODE_*)
//     d      in  WIDTH  parallel load data
//     sin_l  in  1      serial input entering the MSB on SHR
//     sin_r  in  1      serial input entering the LSB on SHL
//     q_next out WIDTH  value the register takes if the op is applied
// ----------------------------------------------------------------------------
module univ_shift_next
    import univ_shift_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] op,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q_next
);

    always_comb begin
        q_next = q;
        case (op)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_next = RESET_VAL;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal register: hold, load, shift, rotate, arithmetic
//   shift right and clear, plus a burst sequencer that repeats a latched
//   operation `amount` times under a start/busy/done handshake.
//   Ports:
//     clk     in  1      rising-edge clock
//     reset   in  1      asynchronous, active-high reset
//     en      in  1      op enable; stalls a running burst when low
//     mode    in  3      op select (MODE_*)
//     d       in  WIDTH  parallel load data
//     sin_l   in  1      serial in, MSB side (SHR)
//     sin_r   in  1      serial in, LSB side (SHL)
//     start   in  1      begin a burst of `amount` repetitions of `mode`
//     amount  in  AMT_W  burst repeat count
//     q       out WIDTH  register contents
//     sout_l  out 1      q[WIDTH-1]
//     sout_r  out 1      q[0]
//     busy    out 1      high while a burst is executing
//     done    out 1      one-cycle pulse when a burst completes
// ----------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      AMT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic              start,
    input  logic [AMT_W-1:0]  amount,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic [AMT_W-1:0]    cnt_q, cnt_d;
    logic [MODE_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]    dl_q, dl_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [MODE_W-1:0]   sel_op;
    logic [WIDTH-1:0]    sel_d;
    logic [WIDTH-1:0]    q_next;

    // In BURST the latched op/data drive the datapath; in IDLE the live inputs.
    always_comb begin
        sel_op = mode;
        sel_d  = d;
        if (state_q == S_BURST) begin
            sel_op = op_q;
            sel_d  = dl_q;
        end
    end

    univ_shift_next #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_next (
        .q      (q_q),
        .op     (sel_op),
        .d      (sel_d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (q_next)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dl_d    = dl_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Start wins over en: latch the op, leave q untouched.
                    op_d  = mode;
                    dl_d  = d;
                    cnt_d = amount;
                    if (amount != '0) begin
                        busy_d  = 1'b1;
                        state_d = S_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    q_d = q_next;
                end
            end
            S_BURST: begin
                if (en) begin
                    q_d = q_next;
                    if (cnt_q == AMT_W'(1)) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - AMT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            op_q    <= MODE_HOLD;
            dl_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dl_q    <= dl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [3:0] amount;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: register value as an integer, remaining burst
    // repetitions, captured op/data and handshake flags.
    int m_q, m_left, m_op, m_d;
    int m_busy, m_done;

    univ_shift_reg #(
        .WIDTH     (8),
        .AMT_W     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .amount (amount),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operation semantics on an 8-bit value expressed with plain arithmetic.
    function automatic int apply(input int op, input int v, input int dd,
                                 input int sl, input int sr);
        case (op)
            0: return v;
            1: return dd;
            2: return (v * 2 + sr) % 256;
            3: return v / 2 + sl * 128;
            4: return (v * 2) % 256 + v / 128;
            5: return v / 2 + (v % 2) * 128;
            6: return v / 2 + (v / 128) * 128;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_q = 0; m_left = 0; m_op = 0; m_d = 0; m_busy = 0; m_done = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int nd;
        nd = 0;
        if (m_busy != 0) begin
            if (en) begin
                m_q = apply(m_op, m_q, m_d, int'(sin_l), int'(sin_r));
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0;
                    nd = 1;
                end
            end
        end else if (start) begin
            m_op = int'(mode);
            m_d  = int'(d);
            if (amount != 4'd0) begin
                m_left = int'(amount);
                m_busy = 1;
            end else begin
                nd = 1;
            end
        end else if (en) begin
            m_q = apply(int'(mode), m_q, int'(d), int'(sin_l), int'(sin_r));
        end
        m_done = nd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"},      {24'd0, q},      m_q);
        chk({tag, ".busy"},   {31'd0, busy},   m_busy);
        chk({tag, ".done"},   {31'd0, done},   m_done);
        chk({tag, ".sout_l"}, {31'd0, sout_l}, m_q / 128);
        chk({tag, ".sout_r"}, {31'd0, sout_r}, m_q % 2);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".async_q"},    {24'd0, q},    32'd0);
        chk({tag, ".async_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".async_done"}, {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dd,
                         input logic sl, input logic sr, input logic st,
                         input logic [3:0] amt);
        en = e; mode = m; d = dd; sin_l = sl; sin_r = sr; start = st; amount = amt;
    endtask

    initial begin
        int busy_cycles;

        reset = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        model_reset();
        #1;
        chk_all("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while holding a non-zero value.
        drive(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0);
        step("load_a5");
        chk("load_a5.const", {24'd0, q}, 32'hA5);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        async_reset("rst_a5");
        chk_all("rst_a5.after");

        // Single operations.
        drive(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        step("load_81");
        drive(1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        step("shl");
        chk("shl.const", {24'd0, q}, 32'h03);
        drive(1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("ror");
        chk("ror.const", {24'd0, q}, 32'h81);
        drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("asr");
        chk("asr.const", {24'd0, q}, 32'hC0);
        drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("clr");
        chk("clr.const", {24'd0, q}, 32'h00);

        // Burst ROL x3 from 01; start with en high must not move q.
        drive(1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        step("b3_load");
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        step("b3_start");
        chk("b3_start.q_unchanged", {24'd0, q}, 32'h01);
        busy_cycles = int'(busy);
        drive(1'b1, 3'd1, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            step("b3_run");
            busy_cycles += int'(busy);
        end
        chk("b3.q_final", {24'd0, q}, 32'h08);
        chk("b3.done", {31'd0, done}, 32'd1);
        chk("b3.busy_cycles", busy_cycles, 32'd3);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("b3_done_clear");

        // Same burst with a two-cycle stall.
        drive(1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        step("st_load");
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        step("st_start");
        busy_cycles = int'(busy);
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("st_run1");
        busy_cycles += int'(busy);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step("st_stall");
            chk("st_stall.q_hold", {24'd0, q}, 32'h02);
            busy_cycles += int'(busy);
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step("st_run2");
            busy_cycles += int'(busy);
        end
        chk("st.q_final", {24'd0, q}, 32'h08);
        chk("st.busy_cycles", busy_cycles, 32'd5);

        // amount = 0: done next cycle, never busy, q unchanged.
        drive(1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0);
        step("amt0_start");
        chk("amt0.done", {31'd0, done}, 32'd1);
        chk("amt0.q", {24'd0, q}, 32'h08);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("amt0_after");

        // Maximum amount: 15 rotations right of 01.
        drive(1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        step("max_load");
        drive(1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd15);
        step("max_start");
        busy_cycles = int'(busy);
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) begin
            step("max_run");
            busy_cycles += int'(busy);
        end
        chk("max.q_final", {24'd0, q}, 32'h02);
        chk("max.busy_cycles", busy_cycles, 32'd15);

        // Reset in the middle of a burst, then a fresh burst.
        drive(1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        step("rb_load");
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        step("rb_start");
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("rb_run");
        async_reset("rb_rst");
        chk_all("rb_rst.after");
        en = 1'b0;
        step("rb_no_done");
        drive(1'b1, 3'd1, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0);
        step("rb_reload");
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
        step("rb_restart");
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step("rb_rerun1");
        step("rb_rerun2");
        chk("rb.q_final", {24'd0, q}, 32'h0C);
        chk("rb.done", {31'd0, done}, 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
                async_reset("rnd_rst");
            end
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  4'($urandom_range(0, 15)));
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
